// File: rtl/gnn_0_example_save.sv
// Save engine: streams N buffer lines through a 2-entry skid FIFO to a DRAM write master.
// Optional macro SAVE_STALL_COUNT_EN enables the backpressure cycle counter on stall_cycles.
module gnn_0_example_save #(
  parameter int SAVE_INST_LENGTH   = 96,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32
) (
  input  logic                          kernel_clk,
  input  logic                          kernel_rst,
  input  logic                          ap_start,
  output logic                          ap_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  input  logic [SAVE_INST_LENGTH-1:0]   ctrl_instruction,
  output logic                          save_read_buffer_valid,
  output logic [3:0]                    save_read_buffer_id,
  output logic [10:0]                   save_read_buffer_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] save_read_buffer_data,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] dram_xfer_start_addr,
  output logic [C_XFER_SIZE_WIDTH-1:0]  dram_xfer_size_in_bytes,
  output logic                          write_start,
  input  logic                          write_done,
  output logic                          data_tvalid,
  input  logic                          data_tready,
  output logic                          data_tlast,
  output logic [C_M_AXI_DATA_WIDTH-1:0] data_tdata,
  output logic [31:0]                   stall_cycles
);

  // state     | meaning
  // IDLE      | waiting for ap_start, instruction latched on accept
  // START     | one-cycle write_start pulse to the write master
  // STREAM    | issuing buffer reads and forwarding lines to the stream
  // WAIT_DONE | all beats sent, waiting for write_done
  // DONE      | one-cycle ap_done pulse
  typedef enum logic [2:0] {IDLE, START, STREAM, WAIT_DONE, DONE} state_t;

  state_t      state;
  logic [15:0] line_cnt;
  logic [15:0] rd_cnt;
  logic [15:0] beat_cnt;
  logic [10:0] rd_addr;
  logic [3:0]  buf_id;
  logic        rd_pending;
  logic        done_seen;

  logic [C_M_AXI_DATA_WIDTH-1:0] fifo_mem [2];
  logic                          fifo_wr_ptr;
  logic                          fifo_rd_ptr;
  logic [1:0]                    fifo_cnt;

  logic       push;
  logic       pop;
  logic       rd_go;
  logic       last_beat;
  logic [2:0] occ_after;
  logic       inst_unused;

  assign inst_unused = ^{ctrl_instruction[15:0], ctrl_instruction[31:20], ctrl_instruction[47:43]};

  assign push        = rd_pending;
  assign data_tvalid = (fifo_cnt != 2'd0);
  assign pop         = data_tvalid && data_tready;
  assign data_tdata  = fifo_mem[fifo_rd_ptr];
  assign data_tlast  = data_tvalid && (beat_cnt == line_cnt - 16'd1);
  assign last_beat   = pop && data_tlast;

  // Read valid is combinational so a line requested this cycle lands in the
  // FIFO two edges later; credit the pop so two slots sustain one beat per cycle.
  assign occ_after = 3'(fifo_cnt) + 3'(rd_pending) - 3'(pop);
  assign rd_go     = (state == STREAM) && (rd_cnt != line_cnt) && (occ_after < 3'd2);

  assign save_read_buffer_valid = rd_go;
  assign save_read_buffer_addr  = rd_addr;
  assign save_read_buffer_id    = buf_id;

  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      state                   <= IDLE;
      line_cnt                <= '0;
      rd_cnt                  <= '0;
      beat_cnt                <= '0;
      rd_addr                 <= '0;
      buf_id                  <= '0;
      rd_pending              <= 1'b0;
      done_seen               <= 1'b0;
      ap_done                 <= 1'b0;
      write_start             <= 1'b0;
      dram_xfer_start_addr    <= '0;
      dram_xfer_size_in_bytes <= '0;
    end else begin
      ap_done     <= 1'b0;
      write_start <= 1'b0;
      rd_pending  <= rd_go;
      case (state)
        IDLE: begin
          if (ap_start) begin
            line_cnt                <= ctrl_instruction[63:48];
            rd_addr                 <= ctrl_instruction[42:32];
            buf_id                  <= ctrl_instruction[19:16];
            rd_cnt                  <= '0;
            beat_cnt                <= '0;
            done_seen               <= 1'b0;
            dram_xfer_start_addr    <= ctrl_addr_offset + C_M_AXI_ADDR_WIDTH'(ctrl_instruction[95:64]);
            dram_xfer_size_in_bytes <= C_XFER_SIZE_WIDTH'({ctrl_instruction[63:48], 6'd0});
            if (ctrl_instruction[63:48] == 16'd0) begin
              state   <= DONE;
              ap_done <= 1'b1;
            end else begin
              state       <= START;
              write_start <= 1'b1;
            end
          end
        end
        START: begin
          if (write_done) done_seen <= 1'b1;
          state <= STREAM;
        end
        STREAM: begin
          if (rd_go) begin
            rd_addr <= rd_addr + 11'd1;
            rd_cnt  <= rd_cnt + 16'd1;
          end
          if (pop) beat_cnt <= beat_cnt + 16'd1;
          if (write_done) done_seen <= 1'b1;
          if (last_beat) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done_seen || write_done) begin
            state   <= DONE;
            ap_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      fifo_mem    <= '{default: '0};
      fifo_wr_ptr <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[fifo_wr_ptr] <= save_read_buffer_data;
        fifo_wr_ptr           <= ~fifo_wr_ptr;
      end
      if (pop) fifo_rd_ptr <= ~fifo_rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
    end
  end

`ifdef SAVE_STALL_COUNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      stall_q <= '0;
    end else if (state == IDLE && ap_start) begin
      stall_q <= '0;
    end else if (data_tvalid && !data_tready && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_gnn_0_example_save.sv
// Randomized bench for gnn_0_example_save: buffer responder, write-master model and
// a transaction-level expectation of addresses, beats, pulses and stall counts.
module tb_gnn_0_example_save;

  logic         kernel_clk;
  logic         kernel_rst;
  logic         ap_start;
  logic         ap_done;
  logic [63:0]  ctrl_addr_offset;
  logic [95:0]  ctrl_instruction;
  logic         save_read_buffer_valid;
  logic [3:0]   save_read_buffer_id;
  logic [10:0]  save_read_buffer_addr;
  logic [511:0] save_read_buffer_data;
  logic [63:0]  dram_xfer_start_addr;
  logic [31:0]  dram_xfer_size_in_bytes;
  logic         write_start;
  logic         write_done;
  logic         data_tvalid;
  logic         data_tready;
  logic         data_tlast;
  logic [511:0] data_tdata;
  logic [31:0]  stall_cycles;

  int          n_chk = 0;
  int          n_bad = 0;
  logic [31:0] salt = 32'h0;

  gnn_0_example_save dut (
    .kernel_clk              (kernel_clk),
    .kernel_rst              (kernel_rst),
    .ap_start                (ap_start),
    .ap_done                 (ap_done),
    .ctrl_addr_offset        (ctrl_addr_offset),
    .ctrl_instruction        (ctrl_instruction),
    .save_read_buffer_valid  (save_read_buffer_valid),
    .save_read_buffer_id     (save_read_buffer_id),
    .save_read_buffer_addr   (save_read_buffer_addr),
    .save_read_buffer_data   (save_read_buffer_data),
    .dram_xfer_start_addr    (dram_xfer_start_addr),
    .dram_xfer_size_in_bytes (dram_xfer_size_in_bytes),
    .write_start             (write_start),
    .write_done              (write_done),
    .data_tvalid             (data_tvalid),
    .data_tready             (data_tready),
    .data_tlast              (data_tlast),
    .data_tdata              (data_tdata),
    .stall_cycles            (stall_cycles)
  );

  initial kernel_clk = 1'b0;
  always #5 kernel_clk = ~kernel_clk;

  function automatic logic [511:0] line_data(input logic [31:0] s, input logic [3:0] id,
                                             input logic [10:0] a);
    logic [31:0] w;
    w = {s[11:0], id, 5'd0, a};
    return {16{w}};
  endfunction

  // Buffer model: data for a read appears exactly one cycle after its valid; junk otherwise.
  always @(posedge kernel_clk) begin
    if (save_read_buffer_valid)
      save_read_buffer_data <= line_data(salt, save_read_buffer_id, save_read_buffer_addr);
    else
      save_read_buffer_data <= {16{$urandom}};
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_ap_done"}, ap_done, 0);
    chk({pfx, "_write_start"}, write_start, 0);
    chk({pfx, "_tvalid"}, data_tvalid, 0);
    chk({pfx, "_tlast"}, data_tlast, 0);
    chk({pfx, "_tdata"}, data_tdata, 0);
    chk({pfx, "_rd_valid"}, save_read_buffer_valid, 0);
    chk({pfx, "_rd_id"}, save_read_buffer_id, 0);
    chk({pfx, "_rd_addr"}, save_read_buffer_addr, 0);
    chk({pfx, "_xfer_addr"}, dram_xfer_start_addr, 0);
    chk({pfx, "_xfer_size"}, dram_xfer_size_in_bytes, 0);
    chk({pfx, "_stall"}, stall_cycles, 0);
  endtask

  // mode: 0 tready high, 1 toggling, 2 random. dmode: -1 write_done with last beat,
  // d>=0 write_done d cycles after the cycle following the last beat.
  task automatic run_txn(input int n, input int sl, input int id, input logic [31:0] off,
                         input logic [63:0] base, input int mode, input int dmode,
                         input int inj, input int rst_at);
    int cyc, beats, nrd, ws_n, done_n, ws_cyc, first_v, first_b, last_cyc, wd_cyc, done_cyc;
    int stalls, act;
    logic inj_done, stalled;
    logic [511:0] held;
    logic [95:0] inst, inst2;
    logic [10:0] exp_line;
    inst = '0;
    inst[5:0]   = 6'h2;
    inst[19:16] = id[3:0];
    inst[42:32] = sl[10:0];
    inst[63:48] = n[15:0];
    inst[95:64] = off;
    inst2 = inst;
    inst2[63:48] = 16'd1;
    cyc = 0; beats = 0; nrd = 0; ws_n = 0; done_n = 0; ws_cyc = -1; first_v = -1;
    first_b = -1; last_cyc = -1; wd_cyc = -1; done_cyc = -1; stalls = 0;
    inj_done = 1'b0; stalled = 1'b0; held = '0;
    @(negedge kernel_clk);
    salt = $urandom;
    ctrl_instruction = inst;
    ctrl_addr_offset = base;
    ap_start = 1'b1;
    data_tready = 1'b1;
    write_done = 1'b0;
    while (cyc < 600) begin
      @(negedge kernel_clk);
      cyc++;
      ap_start = 1'b0;
      write_done = 1'b0;
      if (inj != 0 && !inj_done && beats >= 2) begin
        ctrl_instruction = inst2;
        ap_start = 1'b1;
        inj_done = 1'b1;
      end
      if (rst_at >= 0 && beats == rst_at) begin
        kernel_rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        @(negedge kernel_clk);
        kernel_rst = 1'b0;
        act = 0;
        for (int k = 0; k < 8; k++) begin
          @(negedge kernel_clk);
          #1;
          if (data_tvalid || write_start || ap_done || save_read_buffer_valid) act++;
        end
        chk("post_rst_quiet", act, 0);
        return;
      end
      case (mode)
        0:       data_tready = 1'b1;
        1:       data_tready = (cyc % 2 == 1);
        default: data_tready = ($urandom_range(0, 1) == 1);
      endcase
      if (dmode >= 0 && last_cyc >= 0 && cyc == last_cyc + 1 + dmode) begin
        write_done = 1'b1;
        wd_cyc = cyc;
      end
      #1;
      if (stalled) begin
        chk("hold_tvalid", data_tvalid, 1);
        chk("hold_tdata", data_tdata, held);
      end
      stalled = 1'b0;
      if (write_start) begin
        ws_n++;
        ws_cyc = cyc;
        chk("xfer_addr", dram_xfer_start_addr, base + 64'(off));
        chk("xfer_size", dram_xfer_size_in_bytes, 32'(n * 64));
      end
      if (save_read_buffer_valid) begin
        chk("rd_addr", save_read_buffer_addr, (sl + nrd) % 2048);
        chk("rd_id", save_read_buffer_id, id[3:0]);
        nrd++;
      end
      if (data_tvalid && first_v < 0) first_v = cyc;
      if (data_tvalid && !data_tready) begin
        stalls++;
        stalled = 1'b1;
        held = data_tdata;
      end
      if (data_tvalid && data_tready) begin
        exp_line = 11'((sl + beats) % 2048);
        chk("beat_data", data_tdata, line_data(salt, id[3:0], exp_line));
        chk("beat_tlast", data_tlast, (beats == n - 1) ? 1 : 0);
        if (beats == 0) first_b = cyc;
        beats++;
        if (beats == n) begin
          last_cyc = cyc;
          if (dmode < 0) begin
            write_done = 1'b1;
            wd_cyc = cyc;
          end
        end
      end
      if (ap_done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    write_done = 1'b0;
    chk("timeout", (done_cyc >= 0) ? 1 : 0, 1);
    chk("done_pulses", done_n, 1);
    chk("beats", beats, n);
    chk("reads", nrd, n);
    chk("ws_count", ws_n, (n != 0) ? 1 : 0);
    if (n == 0) begin
      chk("n0_done_lat", (done_cyc >= 1 && done_cyc <= 3) ? 1 : 0, 1);
    end else begin
      chk("first_tvalid_lat", (first_v > ws_cyc && first_v - ws_cyc <= 3) ? 1 : 0, 1);
      if (mode == 0) chk("throughput", last_cyc - first_b, n - 1);
      if (dmode >= 0) chk("done_lat", done_cyc - wd_cyc, 1);
      else chk("done_lat_same", (done_cyc - wd_cyc >= 1 && done_cyc - wd_cyc <= 2) ? 1 : 0, 1);
    end
`ifdef SAVE_STALL_COUNT_EN
    chk("stall_cycles", stall_cycles, stalls);
`else
    chk("stall_cycles", stall_cycles, 0);
`endif
  endtask

  initial begin
    kernel_rst = 1'b1;
    ap_start = 1'b0;
    write_done = 1'b0;
    data_tready = 1'b0;
    ctrl_addr_offset = '0;
    ctrl_instruction = '0;
    repeat (3) @(negedge kernel_clk);
    #1;
    chk_zero("reset");
    @(negedge kernel_clk);
    kernel_rst = 1'b0;
    repeat (2) @(negedge kernel_clk);

    run_txn(4, 0, 3, 32'h100, 64'h1000, 0, 2, 0, -1);
    chk("basic_addr", dram_xfer_start_addr, 64'h1100);
    chk("basic_size", dram_xfer_size_in_bytes, 256);
    run_txn(8, 17, 5, 32'h40, 64'h2000, 1, 1, 0, -1);
    run_txn(0, 9, 1, 32'h0, 64'h3000, 0, 0, 0, -1);
    run_txn(4, 2046, 7, 32'h80, 64'h4000, 2, 0, 0, -1);
    run_txn(8, 100, 2, 32'h200, 64'h5000, 0, 0, 0, 3);
    run_txn(2, 300, 9, 32'h300, 64'h6000, 0, 1, 0, -1);
    run_txn(6, 50, 4, 32'h400, 64'h7000, 0, 2, 1, -1);
    run_txn(5, 2040, 11, 32'h500, 64'h8000, 0, -1, 0, -1);
    for (int t = 0; t < 8; t++) begin
      run_txn($urandom_range(0, 20), $urandom_range(0, 2047), $urandom_range(0, 15),
              $urandom, {$urandom, $urandom}, $urandom_range(0, 2),
              int'($urandom_range(0, 4)) - 1, 0, -1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/gnn_0_example_save.md
GNN_0_EXAMPLE_SAVE -- requirements
Module: gnn_0_example_save

Interface
REQ-001 SHALL have parameter SAVE_INST_LENGTH, default 96, instruction width.
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 64, DRAM address width.
REQ-003 SHALL have parameter C_M_AXI_DATA_WIDTH, default 512, line width.
REQ-004 SHALL have parameter C_XFER_SIZE_WIDTH, default 32, byte-count width.
REQ-005 SHALL have port kernel_clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port kernel_rst, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have ports ap_start (in, 1) and ap_done (out, 1): one-cycle start and done pulses.
REQ-008 SHALL have port ctrl_addr_offset, input, C_M_AXI_ADDR_WIDTH, DRAM base address.
REQ-009 SHALL have port ctrl_instruction, input, SAVE_INST_LENGTH, instruction sampled on ap_start.
REQ-010 SHALL have buffer read ports: save_read_buffer_valid (out, 1), save_read_buffer_id (out, 4), save_read_buffer_addr (out, 11), save_read_buffer_data (in, C_M_AXI_DATA_WIDTH, valid exactly 1 cycle after valid).
REQ-011 SHALL have write-master control ports: dram_xfer_start_addr (out, C_M_AXI_ADDR_WIDTH), dram_xfer_size_in_bytes (out, C_XFER_SIZE_WIDTH), write_start (out, 1, pulse), write_done (in, 1, pulse).
REQ-012 SHALL have stream ports: data_tvalid (out, 1), data_tready (in, 1), data_tlast (out, 1), data_tdata (out, C_M_AXI_DATA_WIDTH).
REQ-013 SHALL have port stall_cycles, output, 32, backpressure counter (see Configuration).

Function
REQ-014 SHALL decode instruction: [5:0] opcode, [15:6] reserved, [19:16] buffer id, [42:32] buffer start line, [63:48] line count N, [95:64] DRAM byte offset.
REQ-015 SHALL drive dram_xfer_start_addr = ctrl_addr_offset + zero-extended offset, and dram_xfer_size_in_bytes = N<<6, both held stable from write_start to write_done.
REQ-016 SHALL implement FSM IDLE -> START -> STREAM -> WAIT_DONE -> DONE -> IDLE.
REQ-017 IDLE: on ap_start latch fields; N==0 goes directly to DONE without write_start; else START.
REQ-018 START: assert write_start for exactly one cycle, then STREAM.
REQ-019 STREAM: issue N buffer reads at consecutive addresses from start line; address wraps modulo 2048.
REQ-020 SHALL hold returned lines in a 2-entry skid FIFO; a read issues only when FIFO occupancy plus in-flight reads < 2; no line dropped or duplicated under any data_tready pattern.
REQ-021 SHALL present FIFO head on data_tdata with data_tvalid=1 whenever FIFO non-empty; transfer occurs on data_tvalid&&data_tready; tvalid/tdata SHALL NOT change until transfer.
REQ-022 SHALL assert data_tlast on the N-th beat only.
REQ-023 After the N-th transfer SHALL enter WAIT_DONE; on write_done enter DONE; write_done arriving the same cycle as the last transfer SHALL be honoured.
REQ-024 DONE: assert ap_done for exactly one cycle, return to IDLE.
REQ-025 ap_start outside IDLE SHALL be ignored.
REQ-026 Best-case throughput SHALL be one beat per cycle with data_tready held high; first tvalid no later than 3 cycles after write_start.

Reset
REQ-027 On kernel_rst assertion SHALL immediately go to IDLE, empty FIFO, cancel in-flight reads, clear counters.
REQ-028 During/after reset all outputs SHALL be 0: ap_done, write_start, data_tvalid, data_tlast, data_tdata, save_read_buffer_valid/id/addr, dram_xfer_start_addr, dram_xfer_size_in_bytes, stall_cycles.
REQ-029 Reset mid-transfer SHALL produce no further beats, write_start or ap_done until a new ap_start.

Configuration
REQ-030 Macro SAVE_STALL_COUNT_EN defined: stall_cycles SHALL count cycles with data_tvalid=1 and data_tready=0, clear on ap_start accepted in IDLE, saturate at 2^32-1.
REQ-031 Macro undefined: stall_cycles SHALL be constant 0 and the counter SHALL not be synthesized.

Verification
REQ-032 N=4, start line 0, offset 0x100, base 0x1000, tready=1 -> write_start once, start addr 0x1100, size 256, 4 consecutive beats with buffer lines 0..3, tlast on beat 4, ap_done one cycle after write_done.
REQ-033 N=8, tready toggling 1/0 each cycle -> exactly 8 beats, data in order, tdata stable while stalled, stall_cycles=7 (8 with final) per macro setting; 0 with macro off.
REQ-034 N=0 -> no write_start, no beats, ap_done within 3 cycles of ap_start.
REQ-035 Start line 2046, N=4 -> read addresses 2046, 2047, 0, 1.
REQ-036 kernel_rst asserted after 3 of 8 beats -> all outputs 0 immediately; next ap_start with N=2 completes normally.
REQ-037 ap_start pulsed during STREAM -> ignored, current transfer unaffected, single ap_done.
